// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared state encoding and helpers for clk_enable_scheduler
package clk_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  localparam int unsigned MASK_W = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_sel);
    return (sel > max_sel) ? max_sel : sel;
  endfunction

  // sel = 0 gives an empty mask, so the comparator matches on every run cycle
  function automatic logic [MASK_W-1:0] sel_mask(input int unsigned sel);
    return (sel >= MASK_W) ? {MASK_W{1'b1}} : ~({MASK_W{1'b1}} << sel);
  endfunction

endpackage

// File: rtl/tick_match.sv
// rtl/tick_match.sv - per-channel boundary detector: low sel bits of the counter all ones
module tick_match
  import clk_sched_pkg::*;
#(
  parameter int CNT_W = 19,
  parameter int SEL_W = 5
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             run_i,
  output logic             match_o
);

  logic [MASK_W-1:0] mask;
  logic [MASK_W-1:0] cnt_ext;

  assign mask    = sel_mask(32'(sel_i));
  assign cnt_ext = MASK_W'(cnt_i);
  assign match_o = run_i && ((cnt_ext & mask) == mask);

endmodule

// File: rtl/clk_enable_scheduler.sv
// rtl/clk_enable_scheduler.sv - prescale counter with per-channel divide-by-2^sel enable strobes
module clk_enable_scheduler
  import clk_sched_pkg::*;
#(
  parameter int CNT_W   = 19,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = clog2(NUM_CH),
  parameter int SEL_W   = clog2(CNT_W + 1),
  parameter int DEF_SEL = 19
) (
  input  logic              inputClk,
  input  logic              rstN,
  input  logic              run,
  input  logic              cfgValid,
  output logic              cfgReady,
  input  logic [CH_W-1:0]   cfgCh,
  input  logic [SEL_W-1:0]  cfgSel,
  output logic              cfgDone,
  output logic [NUM_CH-1:0] tickEn,
  output logic [CNT_W-1:0]  count
);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] match;
  logic [SEL_W-1:0]  sel_q [NUM_CH];

  sched_state_e      state_q;
  logic [CH_W-1:0]   pch_q;
  logic [SEL_W-1:0]  psel_q;
  logic              ready_q;
  logic              done_q;
  logic              pend_match;
  logic              ch_legal;

  assign cnt_d = run ? cnt_q + CNT_W'(1) : cnt_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tick_match #(
      .CNT_W (CNT_W),
      .SEL_W (SEL_W)
    ) u_match (
      .cnt_i   (cnt_q),
      .sel_i   (sel_q[c]),
      .run_i   (run),
      .match_o (match[c])
    );
  end

  always_comb begin
    pend_match = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pch_q == CH_W'(c)) pend_match = match[c];
    end
  end

  assign ch_legal = (32'(cfgCh) < NUM_CH);

  always_ff @(posedge inputClk or negedge rstN) begin
    if (!rstN) begin
      cnt_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= match;
    end
  end

  // A new sel lands on the edge of a match, so that tick fires at the old rate
  // and the next period is measured entirely at the new one.
  always_ff @(posedge inputClk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      pch_q   <= '0;
      psel_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) sel_q[c] <= SEL_W'(DEF_SEL);
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfgValid && ready_q) begin
            pch_q   <= cfgCh;
            psel_q  <= SEL_W'(clamp_sel(32'(cfgSel), CNT_W));
            ready_q <= 1'b0;
            if (ch_legal) begin
              state_q <= WAIT;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!run || pend_match) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (pch_q == CH_W'(c)) sel_q[c] <= psel_q;
            end
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfgReady = ready_q;
  assign cfgDone  = done_q;
  assign tickEn   = tick_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// tb/tb_clk_enable_scheduler.sv - reference-model bench for clk_enable_scheduler
module tb_clk_enable_scheduler;

  localparam int CNT_W = 4;
  localparam int NUM_CH = 4;
  localparam int CH_W = 3;
  localparam int SEL_W = 4;
  localparam int DEF_SEL = 4;
  localparam int MOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic run = 1'b0;
  logic cfgValid = 1'b0;
  logic [CH_W-1:0] cfgCh = '0;
  logic [SEL_W-1:0] cfgSel = '0;
  logic cfgReady;
  logic cfgDone;
  logic [NUM_CH-1:0] tickEn;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  clk_enable_scheduler #(
    .CNT_W (CNT_W),
    .NUM_CH (NUM_CH),
    .CH_W (CH_W),
    .SEL_W (SEL_W),
    .DEF_SEL (DEF_SEL)
  ) dut (
    .inputClk (clk),
    .rstN (rstN),
    .run (run),
    .cfgValid (cfgValid),
    .cfgReady (cfgReady),
    .cfgCh (cfgCh),
    .cfgSel (cfgSel),
    .cfgDone (cfgDone),
    .tickEn (tickEn),
    .count (count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: absolute counter, per-channel period 2^sel, one pending request.
  localparam int M_IDLE = 0;
  localparam int M_PEND = 1;
  localparam int M_ACK = 2;

  int m_cnt;
  int m_sel [NUM_CH];
  bit [NUM_CH-1:0] m_tick;
  int m_phase;
  int m_pch;
  int m_psel;

  always @(posedge clk or negedge rstN) begin : model
    bit [NUM_CH-1:0] hit;
    if (!rstN) begin
      m_cnt <= 0;
      for (int c = 0; c < NUM_CH; c++) m_sel[c] <= DEF_SEL;
      m_tick <= '0;
      m_phase <= M_IDLE;
      m_pch <= 0;
      m_psel <= 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        hit[c] = run && (((m_cnt + 1) % (1 << m_sel[c])) == 0);
      case (m_phase)
        M_IDLE: if (cfgValid) begin
          m_pch <= int'(cfgCh);
          m_psel <= (int'(cfgSel) > CNT_W) ? CNT_W : int'(cfgSel);
          m_phase <= (int'(cfgCh) >= NUM_CH) ? M_ACK : M_PEND;
        end
        M_PEND: if (!run || hit[m_pch]) begin
          m_sel[m_pch] <= m_psel;
          m_phase <= M_ACK;
        end
        default: m_phase <= M_IDLE;
      endcase
      m_tick <= hit;
      if (run) m_cnt <= (m_cnt + 1) % MOD;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", int'(count), m_cnt);
      chk("tickEn", int'(tickEn), int'(m_tick));
      chk("cfgReady", int'(cfgReady), (m_phase == M_IDLE) ? 1 : 0);
      chk("cfgDone", int'(cfgDone), (m_phase == M_ACK) ? 1 : 0);
    end
  end

  task automatic wait_count(input int v);
    int k;
    k = 0;
    while (int'(count) != v && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k == 40) chk("wait_count_timeout", int'(count), v);
  endtask

  task automatic send(input int ch, input int sel);
    int k;
    cfgValid = 1'b1;
    cfgCh = CH_W'(ch);
    cfgSel = SEL_W'(sel);
    k = 0;
    while (!cfgReady && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk("send_ready_timeout", 0, 1);
    @(negedge clk);
    cfgValid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!cfgDone && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k == 60) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int k;
    bit acc;

    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(cfgReady), 1);
    chk("rst_tick", int'(tickEn), 0);
    chk("rst_done", int'(cfgDone), 0);

    rstN = 1'b1;
    run = 1'b1;
    repeat (15) @(negedge clk);
    chk("pre_first_tick", int'(tickEn), 0);
    chk("pre_first_count", int'(count), 15);
    @(negedge clk);
    chk("first_tick", int'(tickEn), 15);
    chk("first_tick_count", int'(count), 0);

    // ch1 -> every cycle, switching at the cnt=15 boundary
    wait_count(5);
    send(1, 0);
    chk("wait_ready_low", int'(cfgReady), 0);
    wait_done();
    chk("switch_count", int'(count), 0);
    chk("switch_tick1", int'(tickEn[1]), 1);
    @(negedge clk);
    chk("after_switch_tick1", int'(tickEn[1]), 1);
    chk("after_switch_ready", int'(cfgReady), 1);

    // ch2 -> divide by 4
    send(2, 2);
    wait_done();
    n = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (tickEn[2]) begin
        n++;
        chk("div4_phase", int'(count) % 4, 0);
      end
    end
    chk("div4_ticks", n, 6);

    // run gating while waiting
    wait_count(2);
    send(0, 1);
    run = 1'b0;
    @(negedge clk);
    chk("gate_done", int'(cfgDone), 1);
    chk("gate_tick", int'(tickEn), 0);
    chk("gate_count", int'(count), 3);
    repeat (3) @(negedge clk);
    chk("gate_frozen", int'(count), 3);
    run = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tickEn[0]) n++;
    end
    chk("div2_ticks", n, 4);

    // illegal channel and oversized select
    send(5, 3);
    chk("badch_done", int'(cfgDone), 1);
    @(negedge clk);
    chk("badch_ready", int'(cfgReady), 1);
    send(3, 9);
    wait_done();
    k = 0;
    while (!tickEn[3] && k < 40) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tickEn[3] && k < 40);
    chk("clamp_period", k, 16);

    // async reset while a request is pending
    wait_count(1);
    send(3, 2);
    #2 rstN = 1'b0;
    #1;
    chk("areset_count", int'(count), 0);
    chk("areset_ready", int'(cfgReady), 1);
    chk("areset_tick", int'(tickEn), 0);
    chk("areset_done", int'(cfgDone), 0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfgDone) n++;
      if (i == 15) chk("areset_tick16", int'(tickEn), 15);
    end
    chk("areset_no_done", n, 0);

    // randomized run gating and reconfiguration
    acc = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (acc) cfgValid = 1'b0;
      run = ($urandom_range(0, 5) != 0);
      if (!cfgValid && $urandom_range(0, 3) == 0) begin
        cfgValid = 1'b1;
        cfgCh = CH_W'($urandom_range(0, 5));
        cfgSel = SEL_W'($urandom_range(0, 9));
      end
      acc = cfgValid && cfgReady;
    end
    @(negedge clk);
    cfgValid = 1'b0;
    run = 1'b1;
    repeat (40) @(negedge clk);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_enable_scheduler.md
Name: clk_enable_scheduler

Overview:
- Single-clock replacement for ripple-divided clocks.
- One free-running prescale counter drives NUM_CH one-cycle clock-enable strobes. Each strobe runs at a per-channel divide-by-2^sel rate.
- Rates are reprogrammed at runtime through a valid/ready config port. A new rate is applied only on the target channel's period boundary, so no strobe is shortened or doubled.
- Sits between the system clock and all slow logic: display refresh, debounce, and similar consumers.

Parameters:
- CNT_W, 19, prescale counter width (max divide 2^CNT_W).
- NUM_CH, 4, number of tick channels.
- CH_W, 2, channel index width (clog2 NUM_CH).
- SEL_W, 5, rate-select width (clog2 (CNT_W+1)).
- DEF_SEL, 19, per-channel reset rate select (must be <= CNT_W).

Ports:
- inputClk  in  1  system clock; all state on its rising edge.
- rstN  in  1  reset. Asynchronous assert, active-low.
- run  in  1  global enable. Counter advances and ticks fire only while high.
- cfgValid  in  1  config request valid.
- cfgReady  out  1  scheduler can accept a config.
- cfgCh  in  CH_W  target channel.
- cfgSel  in  SEL_W  new rate: tick every 2^cfgSel cycles.
- cfgDone  out  1  one-cycle pulse when a request completes.
- tickEn  out  NUM_CH  per-channel one-cycle enable strobes.
- count  out  CNT_W  current prescale counter value.

Behaviour:
- Reset values (rstN low, asynchronous):
  - cnt = 0, every sel[c] = DEF_SEL, tickEn = 0, cfgDone = 0, cfgReady = 1.
  - state = IDLE; pending registers cleared.
- Counter:
  - When run = 1: cnt <= cnt + 1, wrapping from 2^CNT_W - 1 to 0.
  - When run = 0: cnt holds.
- Match condition: match[c] = run && (cnt[sel[c]-1:0] all ones). sel[c] = 0 gives match every run cycle.
- tickEn[c] is registered: tickEn[c] <= match[c]. Latency is 1 cycle from the matching count value.
  - Period is exactly 2^sel[c] cycles while run is steady high.
  - run = 0 forces tickEn = 0 on the next edge.
- Clamp: a cfgSel greater than CNT_W is clamped to CNT_W at capture.
- FSM states are IDLE, WAIT, DONE.
- IDLE:
  - cfgReady = 1.
  - On cfgValid & cfgReady: capture pCh = cfgCh and pSel = clamp(cfgSel), then go to WAIT.
  - If cfgCh >= NUM_CH: capture anyway and go straight to DONE, with no sel change.
- WAIT:
  - cfgReady = 0.
  - On the edge where match[pCh] = 1: sel[pCh] <= pSel, go to DONE. That match's tick still fires at the old rate; the new rate counts from the next cycle.
  - If run = 0: apply on the next edge unconditionally, go to DONE.
- DONE:
  - cfgReady = 0, cfgDone = 1 for exactly one cycle, then IDLE.
  - cfgReady rises the cycle after cfgDone.
- Only one outstanding request is allowed. cfgValid in WAIT/DONE is ignored; the requester must hold it until cfgReady.
- Reconfiguring a channel to its current sel still waits for a boundary and still pulses cfgDone.
- Reset mid-WAIT discards the pending request. No cfgDone is produced for it.
- Counter wrap needs no special case: the all-ones match at 2^CNT_W - 1 is the boundary for sel = CNT_W.

Decomposition:
- Shared package (clk_sched_pkg):
  - FSM state encoding (IDLE = 0, WAIT = 1, DONE = 2).
  - clog2 function.
  - Sel clamp function.
  - Mask-generation function: sel mapped to an all-ones low-bit mask.
- One sub-module, tick_match: combinational per-channel comparator (cnt, sel, run -> match), instantiated NUM_CH times.
- The FSM, counter and registers stay in the top module.

Test Plan:
All scenarios use CNT_W = 4, NUM_CH = 4, DEF_SEL = 4.
- Reset/default rate: release rstN with run = 1 -> cnt = 0, cfgReady = 1. Each tickEn[c] first pulses the cycle after cnt = 15, then every 16 cycles.
- Boundary reconfig: at cnt = 5, send ch1, sel 0 ->
  - cfgReady drops and the FSM stays in WAIT until cnt = 15.
  - cfgDone pulses one cycle later.
  - tickEn[1] is then high every cycle, and no tick is lost or duplicated at the switch.
- Divide-by-4: send ch2, sel 2 -> after the boundary, tickEn[2] pulses following cnt = 3, 7, 11, 15, with 4-cycle spacing through the wrap.
- Run gating: in WAIT (ch0, sel 1), drop run ->
  - the request applies next edge and cfgDone pulses;
  - cnt is frozen and tickEn = 0;
  - on raising run, ch0 ticks every 2 cycles.
- Illegal inputs:
  - cfgCh = 5 (CH_W widened for the test) -> accepted, cfgDone the next cycle, no sel changes.
  - cfgSel = 9 -> sel stored as 4.
- Async reset mid-WAIT: assert rstN low between edges -> outputs reset immediately and there is no cfgDone. After release, the default 16-cycle ticks resume.
